// File: rtl/leader_generator_core.sv
// Leader index generator: l = t[4:3] ^ t[1:0], plus valid/change tracking.
// Define LEADER_REG_EN for a registered l output (one-cycle latency, reset to 0).
module leader_generator_core #(
    parameter int T_WIDTH = 5,
    parameter int L_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [T_WIDTH-1:0] t,
    output logic [L_WIDTH-1:0] l,
    output logic               l_valid,
    output logic               l_change
);

    logic [L_WIDTH-1:0] f_idx;
    logic [L_WIDTH-1:0] prev_l_d, prev_l_q;
    logic               l_valid_d, l_valid_q;
    logic               l_change_d, l_change_q;
    logic               t_unused;

    assign t_unused = t[2];

    always_comb begin
        f_idx = t[4:3] ^ t[1:0];
    end

    // Change detection compares f(t) itself in both output modes, so the
    // pulse lines up with the cycle in which the registered l moves.
    always_comb begin
        prev_l_d   = f_idx;
        l_valid_d  = 1'b1;
        l_change_d = l_valid_q && (f_idx != prev_l_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_l_q   <= '0;
            l_valid_q  <= 1'b0;
            l_change_q <= 1'b0;
        end else begin
            prev_l_q   <= prev_l_d;
            l_valid_q  <= l_valid_d;
            l_change_q <= l_change_d;
        end
    end

    assign l_valid  = l_valid_q;
    assign l_change = l_change_q;

`ifdef LEADER_REG_EN
    logic [L_WIDTH-1:0] l_d, l_q;

    always_comb begin
        l_d = f_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q <= '0;
        end else begin
            l_q <= l_d;
        end
    end

    assign l = l_q;
`else
    assign l = f_idx;
`endif

endmodule

// File: tb/tb_leader_generator_core.sv
// Directed bench for leader_generator_core; expectations follow LEADER_REG_EN.
module tb_leader_generator_core;

    logic       clk;
    logic       rst_n;
    logic [4:0] t;
    logic [1:0] l;
    logic       l_valid;
    logic       l_change;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-tabulated f(t) = t[4:3] ^ t[1:0] for t = 0..31
    logic [1:0] exp_f [32] = '{
        2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
        2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2,
        2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
        2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0
    };

    leader_generator_core #(
        .T_WIDTH(5),
        .L_WIDTH(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .t        (t),
        .l        (l),
        .l_valid  (l_valid),
        .l_change (l_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         prev_t;
        logic [1:0] prev_f;

        // Reset held with t=14 (f=3)
        rst_n = 1'b0;
        t     = 5'd14;
        #2;
        check("rst_valid", {31'd0, l_valid}, 32'd0);
        check("rst_change", {31'd0, l_change}, 32'd0);
`ifdef LEADER_REG_EN
        check("rst_l", {30'd0, l}, 32'd0);
`else
        check("rst_l_comb", {30'd0, l}, 32'd3);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", {31'd0, l_valid}, 32'd0);
`ifdef LEADER_REG_EN
        check("rst_hold_l", {30'd0, l}, 32'd0);
`endif

        // Release, then t = 0, 0, 5
        #3;
        rst_n = 1'b1;
        t     = 5'd0;
        edge_sample();
        check("first_valid", {31'd0, l_valid}, 32'd1);
        check("first_no_change", {31'd0, l_change}, 32'd0);
        check("first_l", {30'd0, l}, 32'd0);
        edge_sample();
        check("hold0_change", {31'd0, l_change}, 32'd0);
        t = 5'd5;
        edge_sample();
        check("0to1_change", {31'd0, l_change}, 32'd1);
        check("0to1_l", {30'd0, l}, 32'd1);
        edge_sample();
        check("steady5_change", {31'd0, l_change}, 32'd0);
        check("steady5_valid", {31'd0, l_valid}, 32'd1);

        // Full sweep 0..31
        prev_t = 5;
        prev_f = 2'd1;
        for (int i = 0; i < 32; i++) begin
            t = 5'(i);
            #1;
`ifdef LEADER_REG_EN
            check($sformatf("sweep_pre_l[%0d]", i), {30'd0, l}, {30'd0, exp_f[prev_t]});
`else
            check($sformatf("sweep_comb_l[%0d]", i), {30'd0, l}, {30'd0, exp_f[i]});
`endif
            edge_sample();
            check($sformatf("sweep_post_l[%0d]", i), {30'd0, l}, {30'd0, exp_f[i]});
            check($sformatf("sweep_change[%0d]", i), {31'd0, l_change},
                  {31'd0, exp_f[i] != prev_f});
            prev_f = exp_f[i];
            prev_t = i;
        end

        // Wrap 31 -> 0: both map to 0
        t = 5'd0;
        edge_sample();
        check("wrap_change", {31'd0, l_change}, 32'd0);
        check("wrap_l", {30'd0, l}, 32'd0);

        // t=14 then t=0: registered l lags by one cycle
        t = 5'd14;
        edge_sample();
        check("t14_l", {30'd0, l}, 32'd3);
        check("t14_change", {31'd0, l_change}, 32'd1);
        t = 5'd0;
        #1;
`ifdef LEADER_REG_EN
        check("t0_lag_l", {30'd0, l}, 32'd3);
`else
        check("t0_comb_l", {30'd0, l}, 32'd0);
`endif
        edge_sample();
        check("t0_l", {30'd0, l}, 32'd0);
        check("t0_change", {31'd0, l_change}, 32'd1);

        // Partial-cycle reset while l_change is high
        t = 5'd19;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, l_valid}, 32'd0);
        check("mid_rst_change", {31'd0, l_change}, 32'd0);
`ifdef LEADER_REG_EN
        check("mid_rst_l", {30'd0, l}, 32'd0);
`else
        check("mid_rst_l_comb", {30'd0, l}, 32'd1);
`endif
        #2;
        rst_n = 1'b1;
        edge_sample();
        check("post_rst_valid", {31'd0, l_valid}, 32'd1);
        check("post_rst_no_change", {31'd0, l_change}, 32'd0);
        check("post_rst_l", {30'd0, l}, 32'd1);
        edge_sample();
        check("post_rst_hold", {31'd0, l_change}, 32'd0);
        t = 5'd0;
        edge_sample();
        check("post_rst_1to0", {31'd0, l_change}, 32'd1);
        edge_sample();
        check("post_rst_pulse_end", {31'd0, l_change}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/leader_generator_core.md
LEADER_GENERATOR_CORE -- requirements
Module: leader_generator

Interface
REQ-001 The module SHALL expose parameter T_WIDTH, default 5, giving the width of the time-step input (only 5 is required to be supported).
REQ-002 The module SHALL expose parameter L_WIDTH, default 2, giving the width of the leader index (only 2 is required to be supported).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port t, input, T_WIDTH bits: current time step, 0..31.
REQ-006 The module SHALL have port l, output, L_WIDTH bits: leader index selected for time step t.
REQ-007 The module SHALL have port l_valid, output, 1 bit: high when l holds a value computed from a sampled or current t.
REQ-008 The module SHALL have port l_change, output, 1 bit: one-cycle pulse when the leader index differs from the previous cycle's index.

Function
REQ-009 The leader function SHALL be f(t) = t[4:3] XOR t[1:0] (2-bit bitwise XOR); t[2] does not affect the result.
REQ-010 f SHALL be total over all 32 values of t; there are no illegal or don't-care inputs.
REQ-011 Without LEADER_REG_EN, l SHALL equal f(t) combinationally, with zero-cycle latency and no dependence on clk or rst_n.
REQ-012 With LEADER_REG_EN, l SHALL be a register loaded with f(t) on every rising clk edge, giving one-cycle latency.
REQ-013 The module SHALL hold a register prev_l that captures the current leader index on every rising clk edge.
REQ-014 l_change SHALL be a registered signal, asserted for exactly one cycle after an edge where the newly captured index differs from prev_l and l_valid was already high.
REQ-015 l_valid SHALL be a register that goes high on the first rising clk edge after rst_n deasserts and stays high until the next reset.
REQ-016 The first valid sample after reset SHALL NOT generate l_change.
REQ-017 If t holds steady, l_change SHALL remain low.
REQ-018 The wrap of t from 31 to 0 SHALL be treated like any other transition (f(31)=0 and f(0)=0, so no pulse).
REQ-019 All arithmetic SHALL be unsigned with no carries.

Reset
REQ-020 While rst_n is low, l_valid, l_change and prev_l SHALL be 0 immediately, without waiting for a clock edge.
REQ-021 While rst_n is low and LEADER_REG_EN is defined, l SHALL be 0 immediately; without the macro, l SHALL remain combinational f(t).
REQ-022 A reset asserted mid-operation SHALL discard all history; after release the module SHALL behave exactly as after power-up.
REQ-023 Reset deassertion SHALL take effect at the next rising clk edge.

Configuration
REQ-024 Macro LEADER_REG_EN SHALL select the registered output path (one-cycle latency, output reset to 0) when defined.
REQ-025 When LEADER_REG_EN is undefined, the output path SHALL be purely combinational.
REQ-026 l_valid, l_change and prev_l SHALL be present and behave identically whether or not LEADER_REG_EN is defined.

Verification
REQ-027 A bench SHALL sweep t = 0..31 with the macro undefined, checking l against f: t=0 -> 0, t=5 -> 1, t=14 -> 3, t=19 -> 1, t=31 -> 0.
REQ-028 A bench SHALL repeat the sweep with LEADER_REG_EN defined and check that l equals f(t) of the previous cycle, e.g. drive t=14 then t=0 and expect l=3 on the following cycle.
REQ-029 A bench SHALL hold rst_n low with t=14 and LEADER_REG_EN defined, and expect l=0, l_valid=0 and l_change=0 asynchronously.
REQ-030 A bench SHALL release reset and apply t=0, 0, 5: expect l_valid high after the first edge, no l_change on the first sample, and a single l_change pulse when the index moves 0 -> 1.
REQ-031 A bench SHALL step t through 31 then 0 and expect no l_change pulse.
REQ-032 A bench SHALL assert rst_n low for part of a cycle mid-sweep and expect outputs cleared at once, then l_valid to return high after one edge.
